// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited prefetch into a small in-order FIFO.
// Optional IFU_BYPASS_EN forwards a response straight to the core when the FIFO is empty.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        srst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = AW + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        STALL,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t redirect_state;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic active;
    logic redirect;
    logic dropping;
    logic rsp_keep;
    logic fifo_empty;
    logic credit_ok;
    logic drain_done;
    logic req_fire;
    logic bypass;
    logic push;
    logic pop;
    logic unused_ok;

    assign unused_ok   = &{1'b0, redirect_pc[1:0]};
    assign target      = {redirect_pc[31:2], 2'b00};
    assign active      = (state != BOOT);
    assign redirect    = redirect_valid && active;
    assign dropping    = redirect || (state == DRAIN && drop_cnt != '0);
    assign rsp_keep    = imem_rsp_valid && active && !dropping;
    assign fifo_empty  = (fifo_count == '0);
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok   = (credit_used < LIMIT);
    assign drop_nxt    = outstanding - CW'(imem_rsp_valid);
    assign drain_done  = (drop_cnt == '0) ||
                         (drop_cnt == CW'(1) && imem_rsp_valid);
    assign req_fire    = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = fetch_pc;
    assign redirect_state = (drop_nxt != '0) ? DRAIN : FETCH;

`ifdef IFU_BYPASS_EN
    assign bypass = rsp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = !fifo_empty || bypass;
    assign instr       = bypass ? imem_rsp_data : fifo_data[rd_ptr];
    assign instr_pc    = bypass ? rsp_pc : fifo_pc[rd_ptr];

    // Redirect flushes the queue, so a same-cycle pop or push is lost.
    assign pop  = !fifo_empty && instr_ready && !redirect;
    assign push = rsp_keep && !(bypass && instr_ready);

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        unique case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_nxt = redirect_state;
                end else if (credit_ok) begin
                    imem_req_valid = 1'b1;
                end else begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (redirect) begin
                    state_nxt = redirect_state;
                end else if (credit_ok) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    state_nxt = redirect_state;
                end else if (drain_done) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target;
            rsp_pc   <= target;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
        end
    end

    // Outstanding counts every in-flight request, dropped or not.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                drop_cnt <= drop_nxt;
            end else if (state == DRAIN && imem_rsp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port srst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_addr  output  32  fetch word address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid; responses return in request order, no backpressure.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  taken branch/jump, one-cycle pulse.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port instr_valid  output  1  instruction available to the core.
REQ-013 SHALL have port instr  output  32  instruction word.
REQ-014 SHALL have port instr_pc  output  32  address of instr.
REQ-015 SHALL have port instr_ready  input  1  core consumes instr.

Function
REQ-016 SHALL implement FSM states BOOT, FETCH, STALL, DRAIN.
REQ-017 SHALL transition BOOT->FETCH unconditionally one cycle after reset release; no request is issued in BOOT.
REQ-018 SHALL, in FETCH, assert imem_req_valid with imem_req_addr=fetch_pc when outstanding+fifo_count < DEPTH; otherwise go to STALL.
REQ-019 SHALL return STALL->FETCH once outstanding+fifo_count < DEPTH; credit freed by a same-cycle pop or response counts only from the next cycle.
REQ-020 SHALL increment fetch_pc by 4 and outstanding by 1 on each req handshake (valid&ready); fetch_pc wraps 32'hFFFF_FFFC->32'h0.
REQ-021 SHALL decrement outstanding on every imem_rsp_valid; when not dropping, push {data, pc} into the FIFO.
REQ-022 SHALL drive instr_valid = FIFO not empty, with instr/instr_pc = FIFO head; pop on instr_valid&instr_ready.
REQ-023 SHALL, on redirect_valid in any non-BOOT state: clear the FIFO, set fetch_pc = {redirect_pc[31:2],2'b00}, deassert imem_req_valid that cycle, and set drop_cnt = outstanding minus imem_rsp_valid.
REQ-024 SHALL go to DRAIN after a redirect if drop_cnt>0, else FETCH; in DRAIN, issue no requests, discard each response while decrementing drop_cnt, and go to FETCH when drop_cnt reaches 0.
REQ-025 SHALL give redirect priority over a same-cycle pop or push; that pop and push are lost.
REQ-026 SHALL, with a 1-cycle memory, present the redirected instruction with instr_valid 3 cycles after the redirect cycle: req at N+1, rsp at N+2, instr_valid at N+3.
REQ-027 SHALL never push when the FIFO is full; credit accounting guarantees this, and the bench asserts it.

Reset
REQ-028 SHALL, while srst_n=0, asynchronously set state=BOOT, fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, imem_req_valid=0, instr_valid=0.
REQ-029 SHALL discard in-flight responses lost across reset; memory is reset by the same srst_n.

Configuration
REQ-030 SHALL honour macro IFU_BYPASS_EN: when defined, a non-dropped response arriving while the FIFO is empty and no redirect is pending appears on instr/instr_pc with instr_valid in the same cycle; it is pushed only if instr_ready=0.
REQ-031 SHALL, without IFU_BYPASS_EN, always route responses through the FIFO (REQ-026 latency).

Verification
REQ-032 SHALL cover: reset release, memory always ready with 1-cycle latency, instr_ready=1 -> addresses 0x0,0x4,0x8...; first instr_valid at cycle 3 after release, instr_pc=0x0.
REQ-033 SHALL cover: instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests, then imem_req_valid=0, no overflow; release -> PCs 0x0..0xC in order.
REQ-034 SHALL cover: redirect_pc=0x100 with 2 responses outstanding -> both dropped, DRAIN, next instr_pc=0x100.
REQ-035 SHALL cover: redirect_pc=0x203 -> fetch at 0x200.
REQ-036 SHALL cover: RESET_PC=32'hFFFF_FFF8 -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-037 SHALL cover: srst_n low mid-DRAIN -> outputs reset immediately; refetch from RESET_PC; with IFU_BYPASS_EN, FIFO empty and rsp -> instr_valid the same cycle.
